// File: rtl/updn_sched_pkg.sv
// Shared definitions for the interval-counter scheduler.
//   state_e   : scheduler FSM encoding (2 bits)
//   ALL_ONES  : terminal value for up-counting, truncated to WIDTH at use
package updn_sched_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/DW03_updn_ctr.sv
// Behavioural model of the DesignWare up/down counter used by the scheduler.
//   data/load : synchronous parallel load, load is active-low
//   up_dn     : 1 = increment, 0 = decrement
//   cen       : count enable
//   reset     : async active-low
//   count     : counter register
//   tercnt    : all-ones when counting up, zero when counting down
module DW03_updn_ctr #(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] data,
    input  logic             up_dn,
    input  logic             load,
    input  logic             cen,
    input  logic             clk,
    input  logic             reset,
    output logic [width-1:0] count,
    output logic             tercnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!load) begin
            count <= data;
        end else if (cen) begin
            count <= up_dn ? count + width'(1) : count - width'(1);
        end
    end

    assign tercnt = up_dn ? (&count) : ~(|count);

endmodule

// File: rtl/updn_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
//   req     : request vector
//   ptr     : highest-priority index this round
//   gnt_c   : one-hot winner (zero when no request)
//   idx_c   : winner index
//   valid_c : any request present
module updn_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [PTR_W-1:0]   idx_c,
    output logic               valid_c
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid_c && req[cand]) begin
                valid_c     = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updn_ctr_sched.sv
// Time-shares one up/down interval counter between NUM_REQ requesters.
//   clk, reset : clock, async active-high reset
//   req        : per-requester request level, held until done
//   req_up     : count direction per requester, captured at grant
//   req_len    : packed interval lengths, slice i belongs to requester i
//   hold       : global pause of the counter while running
//   grant      : one-hot current owner
//   done       : one-cycle pulse to the owner on interval expiry
//   busy       : scheduler is in LOAD/RUN/DONE
//   count      : live counter value
module updn_ctr_sched
    import updn_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_up,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    input  logic                     hold,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [WIDTH-1:0]         count
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(ALL_ONES);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     id_q, id_d;
    logic                 up_q, up_d;
    logic [WIDTH-1:0]     len_q, len_d;

    logic [NUM_REQ-1:0]   arb_gnt_c;
    logic [PTR_W-1:0]     arb_idx_c;
    logic                 arb_valid_c;
    logic [WIDTH-1:0]     len_arr [NUM_REQ];
    logic                 owner_req_c;
    logic [PTR_W-1:0]     next_ptr_c;
    logic                 load_c;
    logic                 cen_c;
    logic [WIDTH-1:0]     data_c;
    logic                 tercnt;

    // Unpack per-requester lengths
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = req_len[i*WIDTH +: WIDTH];
    end

    updn_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c),
        .valid_c (arb_valid_c)
    );

    assign owner_req_c = req[id_q];
    assign next_ptr_c  = (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + PTR_W'(1);

    // Counter control; enable is dropped at terminal count so the final value
    // is held, and on abort so the counter stays where the owner left it.
    assign load_c = (state_q == S_LOAD);
    assign cen_c  = (state_q == S_RUN) && !hold && !tercnt && owner_req_c;
    assign data_c = up_q ? (TERM_UP - len_q) : len_q;

    DW03_updn_ctr #(
        .width  (WIDTH)
    ) u_ctr (
        .data   (data_c),
        .up_dn  (up_q),
        .load   (~load_c),
        .cen    (cen_c),
        .clk    (clk),
        .reset  (~reset),
        .count  (count),
        .tercnt (tercnt)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            id_q    <= '0;
            up_q    <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            up_q    <= up_d;
            len_q   <= len_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        id_d    = id_q;
        up_d    = up_q;
        len_d   = len_q;

        unique case (state_q)
            S_IDLE: begin
                if (arb_valid_c) begin
                    state_d = S_LOAD;
                    grant_d = arb_gnt_c;
                    id_d    = arb_idx_c;
                    up_d    = req_up[arb_idx_c];
                    len_d   = len_arr[arb_idx_c];
                end
            end
            S_LOAD: begin
                if (!owner_req_c) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr_c;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Abort takes priority over a simultaneous terminal count
                if (!owner_req_c) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr_c;
                end else if (tercnt) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = next_ptr_c;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_updn_ctr_sched.sv
// Self-checking bench for updn_ctr_sched: directed table, corner sequences
// and randomized multi-requester schedules against a transaction-level model.
module tb_updn_ctr_sched;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_up;
    logic [N*W-1:0] req_len;
    logic           hold;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;

    updn_ctr_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_up  (req_up),
        .req_len (req_len),
        .hold    (hold),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Reset and confirm the reset state while reset is held
    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        req_up  = '0;
        req_len = '0;
        hold    = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_done",  32'(done),  0);
        check("rst_busy",  32'(busy),  0);
        check("rst_count", 32'(count), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Directed single-requester table
    typedef struct {
        int id;
        bit up;
        int len;
        int hold_start;
        int hold_len;
        int probe_cyc;
        int probe_cnt;
        int exp_done;
        int exp_cnt;
    } vec_t;

    vec_t tbl[7];

    // Random-schedule model state
    int  lens [N];
    bit  ups  [N];
    bit  hold_seq [512];
    int  exp_id    [N];
    int  exp_start [N];
    int  exp_dcyc  [N];
    int  n_exp;

    // Expected schedule when 'set' is raised together in IDLE at cycle 0 with
    // the pointer at 0 and each requester dropping after its own done.
    task automatic build_schedule(input logic [N-1:0] set);
        logic [N-1:0] pending;
        int ptr, t, id, c, cc, dec;
        pending = set;
        ptr = 0;
        t = 0;
        n_exp = 0;
        while (pending != 0) begin
            id = -1;
            for (int k = 0; k < N; k++) begin
                if (id < 0 && pending[(ptr + k) % N]) id = (ptr + k) % N;
            end
            // first RUN cycle is t+2; after len unpaused RUN cycles the
            // counter is terminal, seen one cycle later, done one after that
            c = t + 1;
            cc = t + 2;
            dec = 0;
            while (dec < lens[id] && cc < 500) begin
                if (!hold_seq[cc]) begin
                    dec++;
                    c = cc;
                end
                cc++;
            end
            exp_id[n_exp]    = id;
            exp_start[n_exp] = t;
            exp_dcyc[n_exp]  = c + 2;
            n_exp++;
            pending[id] = 1'b0;
            ptr = (id + 1) % N;
            t = c + 3;
        end
    endtask

    initial begin
        tbl[0] = '{id:0, up:0, len:5,   hold_start:-1, hold_len:0, probe_cyc:2,   probe_cnt:5,   exp_done:8,   exp_cnt:0};
        tbl[1] = '{id:1, up:1, len:3,   hold_start:-1, hold_len:0, probe_cyc:2,   probe_cnt:252, exp_done:6,   exp_cnt:255};
        tbl[2] = '{id:0, up:0, len:4,   hold_start:4,  hold_len:3, probe_cyc:6,   probe_cnt:2,   exp_done:10,  exp_cnt:0};
        tbl[3] = '{id:2, up:0, len:0,   hold_start:-1, hold_len:0, probe_cyc:2,   probe_cnt:0,   exp_done:3,   exp_cnt:0};
        tbl[4] = '{id:3, up:1, len:255, hold_start:-1, hold_len:0, probe_cyc:2,   probe_cnt:0,   exp_done:258, exp_cnt:255};
        tbl[5] = '{id:1, up:0, len:255, hold_start:-1, hold_len:0, probe_cyc:130, probe_cnt:127, exp_done:258, exp_cnt:0};
        tbl[6] = '{id:2, up:1, len:0,   hold_start:-1, hold_len:0, probe_cyc:2,   probe_cnt:255, exp_done:3,   exp_cnt:255};

        // Directed table
        foreach (tbl[e]) begin
            do_reset();
            for (int k = 0; k <= tbl[e].exp_done + 1; k++) begin
                @(posedge clk);
                #1;
                if (k == 0) begin
                    req = onehot(tbl[e].id);
                    req_up[tbl[e].id] = tbl[e].up;
                    req_len[tbl[e].id*W +: W] = W'(tbl[e].len);
                end
                hold = (k >= tbl[e].hold_start) && (k < tbl[e].hold_start + tbl[e].hold_len);
                @(negedge clk);
                if (k == 1) begin
                    check("tbl_grant", 32'(grant), 32'(onehot(tbl[e].id)));
                    check("tbl_busy",  32'(busy),  1);
                end
                if (k == tbl[e].probe_cyc) check("tbl_probe_count", 32'(count), 32'(tbl[e].probe_cnt));
                if (k == tbl[e].exp_done) begin
                    check("tbl_done",       32'(done),  32'(onehot(tbl[e].id)));
                    check("tbl_done_count", 32'(count), 32'(tbl[e].exp_cnt));
                    req = '0;
                end else begin
                    check("tbl_no_done", 32'(done), 0);
                end
            end
        end

        // Round robin: all four request continuously with len=0
        do_reset();
        for (int k = 0; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) req = '1;
            @(negedge clk);
            if (k % 4 == 1) check("rr_grant", 32'(grant), 32'(onehot(((k - 1) / 4) % N)));
            if (k % 4 == 3) check("rr_done",  32'(done),  32'(onehot(((k - 3) / 4) % N)));
            else            check("rr_no_done", 32'(done), 0);
        end

        // Abort: owner 0 drops at count 2, requester 1 takes over
        do_reset();
        for (int k = 0; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                req = 4'b0011;
                req_len = {8'd0, 8'd0, 8'd5, 8'd5};
            end
            if (k == 5) req[0] = 1'b0;
            @(negedge clk);
            if (k == 1) check("abort_grant0", 32'(grant), 1);
            if (k == 5) check("abort_cnt_at_drop", 32'(count), 2);
            if (k == 6) begin
                check("abort_idle_busy",  32'(busy),  0);
                check("abort_idle_grant", 32'(grant), 0);
                check("abort_cnt_kept",   32'(count), 2);
            end
            if (k == 7) check("abort_grant1", 32'(grant), 2);
            if (k == 8) check("abort_reload", 32'(count), 5);
            if (k == 14) begin
                check("abort_done1", 32'(done), 2);
                req = '0;
            end else begin
                check("abort_no_done", 32'(done), 0);
            end
        end

        // Reset asserted mid-RUN at count 7
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                req = 4'b0001;
                req_len[W-1:0] = 8'd10;
            end
            if (k == 5) begin
                reset = 1'b1;
                #1;
                check("midrst_grant", 32'(grant), 0);
                check("midrst_busy",  32'(busy),  0);
                check("midrst_done",  32'(done),  0);
                check("midrst_count", 32'(count), 0);
            end
            if (k == 7) reset = 1'b0;
            @(negedge clk);
            if (k == 4) check("midrst_pre_count", 32'(count), 8);
            if (k == 8) check("midrst_regrant", 32'(grant), 1);
            if (k == 9) check("midrst_reload", 32'(count), 10);
            check("midrst_no_done", 32'(done), 0);
        end

        // Randomized schedules with random hold
        for (int s = 0; s < 20; s++) begin
            logic [N-1:0] set;
            logic [N-1:0] eg, ed;
            logic eb;
            int ec, last;
            do_reset();
            set = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                lens[i] = $urandom_range(0, 12);
                ups[i]  = 1'($urandom_range(0, 1));
            end
            for (int c = 0; c < 512; c++) hold_seq[c] = ($urandom_range(0, 3) == 0);
            build_schedule(set);
            last = exp_dcyc[n_exp-1];
            for (int k = 0; k <= last + 2; k++) begin
                @(posedge clk);
                #1;
                if (k == 0) begin
                    req = set;
                    for (int i = 0; i < N; i++) begin
                        req_up[i] = ups[i];
                        req_len[i*W +: W] = W'(lens[i]);
                    end
                end
                hold = hold_seq[k];
                @(negedge clk);
                eg = '0;
                ed = '0;
                eb = 1'b0;
                ec = -1;
                for (int e = 0; e < n_exp; e++) begin
                    if (k >= exp_start[e] + 1 && k <= exp_dcyc[e]) begin
                        eg = onehot(exp_id[e]);
                        eb = 1'b1;
                    end
                    if (k == exp_dcyc[e]) begin
                        ed = onehot(exp_id[e]);
                        ec = ups[exp_id[e]] ? 255 : 0;
                    end
                end
                check("rnd_grant", 32'(grant), 32'(eg));
                check("rnd_busy",  32'(busy),  32'(eb));
                check("rnd_done",  32'(done),  32'(ed));
                if (ec >= 0) check("rnd_done_count", 32'(count), 32'(ec));
                req = req & ~ed;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
